efuse_boot_loader: RTL and testbench
====================================

Name: efuse_boot_loader

Overview:
- Sits between the Caravel user Wishbone master and one eFuse Wishbone slave, i.e. between the Wishbone mux slave port and the efuse_wb_mem_64x8 instance.
- After reset, and on request, it owns the eFuse port and reads NUM_BYTES fuse bytes into a flat configuration vector for chip-level trim/config.
- At all other times it arbitrates the eFuse port to the host as a transparent pass-through.
- Host accesses issued while the loader owns the port are stalled (no ack) until the load completes.

Parameters:
- NUM_BYTES, 8, number of fuse bytes auto-loaded; legal range 1..64.
- BASE_ADDR, 32'h30000000, Wishbone byte address of fuse byte 0; byte i is at BASE_ADDR + 4*i.
- TIMEOUT, 255, maximum cycles waited for a single loader ack; 8-bit counter.

Ports:
- clk  in  1  clock (the user Wishbone clock).
- rst_n  in  1  reset, asynchronous, active-low.
- hst_cyc_i  in  1  host Wishbone cycle.
- hst_stb_i  in  1  host strobe.
- hst_we_i  in  1  host write enable.
- hst_sel_i  in  4  host byte select.
- hst_adr_i  in  32  host address.
- hst_dat_i  in  32  host write data.
- hst_dat_o  out  32  host read data.
- hst_ack_o  out  1  host acknowledge.
- ef_cyc_o  out  1  eFuse cycle.
- ef_stb_o  out  1  eFuse strobe.
- ef_we_o  out  1  eFuse write enable.
- ef_sel_o  out  4  eFuse byte select.
- ef_adr_o  out  32  eFuse address.
- ef_dat_o  out  32  eFuse write data.
- ef_dat_i  in  32  eFuse read data (bits 31:8 are zero).
- ef_ack_i  in  1  eFuse acknowledge.
- reload_i  in  1  single-cycle pulse; request a re-load.
- cfg_o  out  NUM_BYTES*8  loaded bytes; byte i in bits [8i+7:8i].
- cfg_valid_o  out  1  high when cfg_o holds a complete, error-free load.
- busy_o  out  1  loader owns the eFuse port.
- err_o  out  1  last load aborted on timeout.

Behaviour:
- Reset (async, rst_n low):
  - cfg_o=0, cfg_valid_o=0, err_o=0, busy_o=0.
  - All ef_* outputs=0, hst_ack_o=0, hst_dat_o=0.
  - FSM=START, index=0, timer=0.
  - Asserting rst_n low mid-transfer drops ef_cyc_o/ef_stb_o immediately (combinationally through the register reset).
- FSM states: START, REQ, GAP, HOST, ERR.
- START: one cycle after reset release, go to REQ with index=0. busy_o=1 from START onward.
- REQ:
  - Registered outputs: ef_cyc_o=ef_stb_o=1, ef_we_o=0, ef_sel_o=4'b0001, ef_adr_o=BASE_ADDR+4*index.
  - On ef_ack_i: capture ef_dat_i[7:0] into cfg byte index, clear timer, go to GAP. The outputs are low in GAP.
  - Each cycle without ack increments timer. Reaching TIMEOUT: err_o=1, cfg_valid_o=0, go to ERR.
- GAP: one idle cycle with cyc/stb low.
  - If index==NUM_BYTES-1: cfg_valid_o=1, err_o=0, busy_o=0, go to HOST.
  - Otherwise: index+1, go to REQ.
- HOST and ERR: pass-through.
  - ef_cyc_o/stb/we/sel/adr/dat_o follow the hst_* inputs combinationally.
  - hst_ack_o=ef_ack_i; hst_dat_o=ef_dat_i. busy_o=0.
- Load latency: NUM_BYTES*(ack latency+1)+1 cycles after reset release. Example: 2-cycle ack latency, NUM_BYTES=8 gives 25 cycles.
- Host while busy:
  - ef_* outputs come only from the loader; hst_ack_o=0 and hst_dat_o=0.
  - A host cycle simply stalls and completes after HOST is entered.
- reload_i:
  - Accepted in HOST or ERR only when hst_cyc_i==0. Then cfg_valid_o=0, err_o=0, go to START on the next cycle.
  - If hst_cyc_i==1, the request is held pending and taken on the first cycle with hst_cyc_i==0.
  - Ignored while busy. Not held pending while busy.
- cfg_o bytes not yet loaded in a re-load keep their previous value. cfg_valid_o gates their use.
- ef_ack_i arriving in GAP/START is ignored.

Test Plan:
- Reset release; model returns byte value 8'hA0+i at address 32'h30000000+4i with 1-cycle ack -> cfg_o=64'hA7A6A5A4A3A2A1A0, cfg_valid_o=1 after 17 cycles, busy_o low, exactly 8 read strobes with sel=4'b0001, no writes.
- Host read of 32'h30000008 issued on cycle 2 after reset -> hst_ack_o stays 0 until HOST, then acks with data 32'h000000A2; no eFuse strobe mixes host and loader addresses.
- Model never acks byte 3, TIMEOUT=255 -> err_o=1 after 255 stalled cycles, cfg_valid_o=0, busy_o=0, host read of byte 0 passes through and acks.
- reload_i pulsed during an active host cycle -> reload deferred until hst_cyc_i falls, then cfg_valid_o drops to 0, a fresh 8-byte load runs, and cfg_valid_o returns to 1 with new fuse values.
- rst_n asserted low while ef_stb_o=1 in REQ for byte 5 -> ef_cyc_o/ef_stb_o=0 immediately, cfg_o=0, cfg_valid_o=0; after release the load restarts at byte 0.
- Host write (we=1, dat=8'h5A) in HOST state -> passed through unchanged to ef_* with its sel; hst_ack_o mirrors ef_ack_i.

Source files
------------

// File: rtl/efuse_boot_loader.sv
// ---------------------------------------------------------------------------
// efuse_boot_loader
//
// Sits between the user Wishbone master (host side) and a single eFuse
// Wishbone slave. After reset, or when a reload is requested, the loader
// takes the eFuse port and reads NUM_BYTES fuse bytes, one Wishbone read
// per byte, into a flat configuration vector. Once the load has finished
// or timed out, the port becomes a transparent combinational pass-through
// for the host. A host cycle issued while the loader owns the port gets
// no ack until the port is handed back, so the cycle simply stalls.
//
// Parameters
//   NUM_BYTES  number of fuse bytes auto-loaded (1..64)
//   BASE_ADDR  byte address of fuse byte 0; byte i lives at BASE_ADDR + 4*i
//   TIMEOUT    cycles to wait for one loader ack before aborting (1..255)
//
// Ports
//   clk, rst_n           Wishbone clock, asynchronous active-low reset
//   hst_*_i / hst_*_o    host-side Wishbone slave port
//   ef_*_o / ef_*_i      eFuse-side Wishbone master port
//   reload_i             one-cycle pulse requesting a fresh load
//   cfg_o                loaded bytes; byte i in bits [8i+7:8i]
//   cfg_valid_o          cfg_o holds a complete, error-free load
//   busy_o               loader currently owns the eFuse port
//   err_o                last load aborted on timeout
// ---------------------------------------------------------------------------
module efuse_boot_loader #(
  parameter int          NUM_BYTES = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // host port
  input  logic                   hst_cyc_i,
  input  logic                   hst_stb_i,
  input  logic                   hst_we_i,
  input  logic [3:0]             hst_sel_i,
  input  logic [31:0]            hst_adr_i,
  input  logic [31:0]            hst_dat_i,
  output logic [31:0]            hst_dat_o,
  output logic                   hst_ack_o,
  // eFuse port
  output logic                   ef_cyc_o,
  output logic                   ef_stb_o,
  output logic                   ef_we_o,
  output logic [3:0]             ef_sel_o,
  output logic [31:0]            ef_adr_o,
  output logic [31:0]            ef_dat_o,
  input  logic [31:0]            ef_dat_i,
  input  logic                   ef_ack_i,
  // control / status
  input  logic                   reload_i,
  output logic [NUM_BYTES*8-1:0] cfg_o,
  output logic                   cfg_valid_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
  // The timer counts completed stalled cycles; the abort fires on the
  // TIMEOUT-th REQ cycle without an ack.
  localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    START,
    REQ,
    GAP,
    HOST,
    ERR
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       index;
  logic [7:0]             timer;
  logic                   pend;
  logic [NUM_BYTES*8-1:0] cfg;
  logic                   cfg_valid;
  logic                   err;
  logic                   busy;

  // Registered loader-side bus drive.
  logic                   ld_cyc;
  logic                   ld_stb;
  logic [3:0]             ld_sel;
  logic [31:0]            ld_adr;

  logic                   pass;
  logic                   reload_req;

  // Fuse bytes are word-spaced on the bus.
  function automatic logic [31:0] byte_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + {{(30 - IDX_W){1'b0}}, idx, 2'b00};
  endfunction

  assign pass       = (state == HOST) || (state == ERR);
  assign reload_req = reload_i || pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START;
      index     <= '0;
      timer     <= '0;
      pend      <= 1'b0;
      cfg       <= '0;
      cfg_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ld_cyc    <= 1'b0;
      ld_stb    <= 1'b0;
      ld_sel    <= '0;
      ld_adr    <= '0;
    end else begin
      case (state)
        START: begin
          busy   <= 1'b1;
          pend   <= 1'b0;
          index  <= '0;
          timer  <= '0;
          ld_cyc <= 1'b1;
          ld_stb <= 1'b1;
          ld_sel <= 4'b0001;
          ld_adr <= byte_addr('0);
          state  <= REQ;
        end

        REQ: begin
          if (ef_ack_i) begin
            cfg[{index, 3'b000} +: 8] <= ef_dat_i[7:0];
            timer  <= '0;
            ld_cyc <= 1'b0;
            ld_stb <= 1'b0;
            ld_sel <= '0;
            ld_adr <= '0;
            state  <= GAP;
          end else if (timer == TIMER_LAST) begin
            // Abort: bytes already captured stay in cfg but are not valid.
            err       <= 1'b1;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            timer     <= '0;
            ld_cyc    <= 1'b0;
            ld_stb    <= 1'b0;
            ld_sel    <= '0;
            ld_adr    <= '0;
            state     <= ERR;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        GAP: begin
          // One idle cycle between reads; a late ack here is ignored.
          if (index == LAST_IDX) begin
            cfg_valid <= 1'b1;
            err       <= 1'b0;
            busy      <= 1'b0;
            state     <= HOST;
          end else begin
            index  <= index + 1'b1;
            ld_cyc <= 1'b1;
            ld_stb <= 1'b1;
            ld_sel <= 4'b0001;
            ld_adr <= byte_addr(index + 1'b1);
            state  <= REQ;
          end
        end

        HOST, ERR: begin
          // A reload never cuts a host cycle short: it waits in pend until
          // the host drops cyc, then takes the port back.
          if (reload_req) begin
            if (!hst_cyc_i) begin
              pend      <= 1'b0;
              cfg_valid <= 1'b0;
              err       <= 1'b0;
              busy      <= 1'b1;
              state     <= START;
            end else begin
              pend <= 1'b1;
            end
          end
        end

        default: begin
          state <= START;
        end
      endcase
    end
  end

  // Port arbitration: the loader's registered drive while it owns the bus,
  // the host's signals straight through otherwise. Because the loader drive
  // is reset asynchronously, asserting rst_n drops ef_cyc_o/ef_stb_o at once.
  always_comb begin
    if (pass) begin
      ef_cyc_o  = hst_cyc_i;
      ef_stb_o  = hst_stb_i;
      ef_we_o   = hst_we_i;
      ef_sel_o  = hst_sel_i;
      ef_adr_o  = hst_adr_i;
      ef_dat_o  = hst_dat_i;
      hst_ack_o = ef_ack_i;
      hst_dat_o = ef_dat_i;
    end else begin
      ef_cyc_o  = ld_cyc;
      ef_stb_o  = ld_stb;
      ef_we_o   = 1'b0;
      ef_sel_o  = ld_sel;
      ef_adr_o  = ld_adr;
      ef_dat_o  = '0;
      hst_ack_o = 1'b0;
      hst_dat_o = '0;
    end
  end

  assign cfg_o       = cfg;
  assign cfg_valid_o = cfg_valid;
  assign busy_o      = busy;
  assign err_o       = err;

endmodule

// File: tb/tb_efuse_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_efuse_boot_loader
//
// Bench for efuse_boot_loader with a behavioural eFuse slave. The slave
// returns fuse_base + i for fuse byte i, acks after `lat` cycles of strobe,
// and can be told never to ack one byte. Expected loader reads and host
// transactions are queued when issued; a negedge monitor pops and compares
// whenever the DUT completes a bus transfer.
// ---------------------------------------------------------------------------
module tb_efuse_boot_loader;

  localparam int          NB   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hst_cyc_i = 1'b0;
  logic            hst_stb_i = 1'b0;
  logic            hst_we_i = 1'b0;
  logic [3:0]      hst_sel_i = '0;
  logic [31:0]     hst_adr_i = '0;
  logic [31:0]     hst_dat_i = '0;
  logic [31:0]     hst_dat_o;
  logic            hst_ack_o;
  logic            ef_cyc_o;
  logic            ef_stb_o;
  logic            ef_we_o;
  logic [3:0]      ef_sel_o;
  logic [31:0]     ef_adr_o;
  logic [31:0]     ef_dat_o;
  logic [31:0]     ef_dat_i;
  logic            ef_ack_i;
  logic            reload_i = 1'b0;
  logic [NB*8-1:0] cfg_o;
  logic            cfg_valid_o;
  logic            busy_o;
  logic            err_o;

  always #5 clk = ~clk;

  efuse_boot_loader #(
    .NUM_BYTES(NB),
    .BASE_ADDR(BASE),
    .TIMEOUT  (255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hst_cyc_i  (hst_cyc_i),
    .hst_stb_i  (hst_stb_i),
    .hst_we_i   (hst_we_i),
    .hst_sel_i  (hst_sel_i),
    .hst_adr_i  (hst_adr_i),
    .hst_dat_i  (hst_dat_i),
    .hst_dat_o  (hst_dat_o),
    .hst_ack_o  (hst_ack_o),
    .ef_cyc_o   (ef_cyc_o),
    .ef_stb_o   (ef_stb_o),
    .ef_we_o    (ef_we_o),
    .ef_sel_o   (ef_sel_o),
    .ef_adr_o   (ef_adr_o),
    .ef_dat_o   (ef_dat_o),
    .ef_dat_i   (ef_dat_i),
    .ef_ack_i   (ef_ack_i),
    .reload_i   (reload_i),
    .cfg_o      (cfg_o),
    .cfg_valid_o(cfg_valid_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // eFuse slave model
  int         lat = 1;
  int         wcnt = 0;
  int         blk = -1;
  logic [7:0] fuse_base = 8'hA0;
  logic       blocked;

  assign blocked  = (blk >= 0) && (ef_adr_o == BASE + (32'(blk) << 2));
  assign ef_ack_i = ef_cyc_o && ef_stb_o && !blocked && (wcnt == lat - 1);
  assign ef_dat_i = {24'h0, fuse_base + ef_adr_o[9:2]};

  always @(posedge clk) begin
    if (ef_cyc_o && ef_stb_o && !ef_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Scoreboard
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } hxn_t;

  logic [31:0] ld_q[$];
  hxn_t        hst_q[$];
  hxn_t        mon_e;
  logic [31:0] mon_a;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_load(input int first, input int last);
    for (int i = first; i <= last; i++) ld_q.push_back(BASE + 32'(i * 4));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_o && ef_cyc_o && ef_stb_o) begin
        check("ld_ctl", {ef_we_o, ef_sel_o}, 5'b00001);
        if (ef_ack_i) begin
          if (ld_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ld_unexpected actual adr=%h required no read", ef_adr_o);
          end else begin
            mon_a = ld_q.pop_front();
            check("ld_adr", ef_adr_o, mon_a);
          end
        end
      end
      if (busy_o && hst_cyc_i) check("stall_no_ack", {hst_ack_o, hst_dat_o}, 0);
      if (hst_ack_o) begin
        if (hst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL hst_unexpected actual ack adr=%h required none", ef_adr_o);
        end else begin
          mon_e = hst_q.pop_front();
          check("hst_in_pass", cfg_valid_o | err_o, 1);
          check("hst_we", ef_we_o, mon_e.we);
          check("hst_sel", ef_sel_o, mon_e.sel);
          check("hst_adr", ef_adr_o, mon_e.adr);
          check("hst_wdat", ef_dat_o, mon_e.wdat);
          check("hst_rdat", hst_dat_o, mon_e.rdat);
        end
      end
    end
  end

  // Host driver: queue expectation, drive one classic cycle, bounded wait.
  task automatic host_access(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] wdat, input logic [31:0] rdat);
    hxn_t e;
    int   k;
    e.we = we; e.sel = sel; e.adr = adr; e.wdat = wdat; e.rdat = rdat;
    hst_q.push_back(e);
    @(posedge clk);
    #1;
    hst_cyc_i = 1'b1; hst_stb_i = 1'b1; hst_we_i = we;
    hst_sel_i = sel; hst_adr_i = adr; hst_dat_i = wdat;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!hst_ack_o && k < 500);
    if (!hst_ack_o) begin
      checks++;
      errors++;
      $display("FAIL host_timeout adr=%h actual no ack after %0d cycles required ack", adr, k);
    end
    @(posedge clk);
    #1;
    hst_cyc_i = 1'b0; hst_stb_i = 1'b0; hst_we_i = 1'b0;
    hst_sel_i = '0; hst_adr_i = '0; hst_dat_i = '0;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!cfg_valid_o && n < bound);
    if (!cfg_valid_o) begin
      checks++;
      errors++;
      $display("FAIL wait_valid actual still invalid after %0d cycles required valid", n);
    end
  endtask

  task automatic pulse_reload();
    @(posedge clk);
    #2 reload_i = 1'b1;
    @(posedge clk);
    #2 reload_i = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    int stall;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cfg", cfg_o, 0);
    check("rst_status", {cfg_valid_o, err_o, busy_o}, 0);
    check("rst_ef_bus", {ef_cyc_o, ef_stb_o, ef_we_o, ef_sel_o}, 0);
    check("rst_ef_adr", ef_adr_o, 0);
    check("rst_hst", {hst_ack_o, hst_dat_o}, 0);

    // Boot load with 1-cycle ack; host read of byte 2 stalls during it
    push_load(0, 7);
    fork
      begin
        rst_n = 1'b1;
        wait_valid(100, n);
      end
      begin
        @(posedge clk);
        host_access(1'b0, 4'hF, BASE + 32'h8, 32'h0, 32'h0000_00A2);
      end
    join
    check("boot_latency", n, 17);
    check("boot_cfg", cfg_o, 64'hA7A6A5A4A3A2A1A0);
    check("boot_status", {busy_o, err_o}, 0);
    check("boot_read_count", ld_q.size(), 0);

    // Pass-through write and read
    host_access(1'b1, 4'b0001, BASE + 32'h4, 32'h0000_005A, 32'h0000_00A1);
    host_access(1'b0, 4'hF, BASE + 32'hC, 32'h0, 32'h0000_00A3);

    // Reload during an active host cycle is deferred
    fuse_base = 8'hB0;
    lat = 4;
    push_load(0, 7);
    fork
      host_access(1'b0, 4'hF, BASE + 32'h10, 32'h0, 32'h0000_00B4);
      begin
        pulse_reload();
        @(negedge clk);
        check("reload_deferred", {cfg_valid_o, busy_o}, 2'b10);
      end
    join
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cfg_valid_o && k < 20);
    check("reload_drop_valid", cfg_valid_o, 0);
    check("reload_drop_cycles", k, 2);
    check("reload_busy", busy_o, 1);
    pulse_reload();  // ignored while busy
    wait_valid(300, n);
    check("reload_cfg", cfg_o, 64'hB7B6B5B4B3B2B1B0);
    check("reload_read_count", ld_q.size(), 0);
    repeat (6) @(negedge clk);
    check("reload_ignored_busy", {cfg_valid_o, busy_o}, 2'b10);
    lat = 1;

    // Byte 3 never acks: timeout after 255 stalled cycles
    fuse_base = 8'hC0;
    blk = 3;
    push_load(0, 2);
    pulse_reload();
    k = 0;
    stall = 0;
    do begin
      @(negedge clk);
      k++;
      if (busy_o && ef_stb_o && ef_adr_o == BASE + 32'hC) stall++;
    end while (!err_o && k < 1000);
    check("timeout_err", err_o, 1);
    check("timeout_cycles", stall, 255);
    check("timeout_status", {cfg_valid_o, busy_o}, 0);
    check("timeout_cfg", cfg_o, 64'hB7B6B5B4B3C2C1C0);
    check("timeout_read_count", ld_q.size(), 0);
    host_access(1'b0, 4'hF, BASE, 32'h0, 32'h0000_00C0);

    // Reset asserted while strobing byte 5
    fuse_base = 8'hA0;
    blk = 5;
    push_load(0, 4);
    pulse_reload();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(ef_stb_o && ef_adr_o == BASE + 32'h14) && k < 100);
    check("mid_stb_byte5", {ef_cyc_o, ef_stb_o, err_o}, 3'b110);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {ef_cyc_o, ef_stb_o}, 0);
    check("mid_rst_cfg", cfg_o, 0);
    check("mid_rst_status", {cfg_valid_o, busy_o, err_o}, 0);
    check("mid_read_count", ld_q.size(), 0);
    blk = -1;
    push_load(0, 7);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(100, n);
    check("restart_latency", n, 17);
    check("restart_cfg", cfg_o, 64'hA7A6A5A4A3A2A1A0);
    check("restart_read_count", ld_q.size(), 0);

    repeat (2) @(negedge clk);
    check("host_queue_empty", hst_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
